seg7_scan_decoder: RTL and testbench
====================================

// Module: seg7_scan_decoder
// PURPOSE
//  Receive-side counterpart of the team's bcd 4-bit -> 7-segment encoder. Samples a multiplexed
//  DIGITS-wide 7-segment bus (one-hot digit select + segment lines), decodes each glyph back to BCD,
//  filters glitches with a per-digit stability count and emits one packed BCD word per complete frame.
//  Sits between a display-bus snooper / front-panel tap and any logic that needs the displayed value.
// PARAMETERS
//  DIGITS      4  number of multiplexed digits (1..8)
//  STABLE_CNT  2  consecutive identical samples needed before a digit is accepted (1..15)
// PORTS
//  clk        in   1           single clock; all logic on posedge
//  reset      in   1           synchronous, active-high
//  sample     in   1           qualifies digit_sel/seg this cycle
//  digit_sel  in   DIGITS      one-hot digit select; bit d = digit d (d=0 least significant)
//  seg        in   7           segments, seg[0]=a .. seg[6]=g, active-high
//  bcd_out    out  4*DIGITS    last complete frame; nibble d = digit d
//  frame_vld  out  1           one-cycle pulse: bcd_out just updated
//  pat_err    out  1           one-cycle pulse: sampled pattern is not a legal glyph
//  sel_err    out  1           sticky: a sample had non-one-hot digit_sel; cleared only by reset
// BEHAVIOUR
//  Reset (sync): bcd_out=0, frame_vld=0, pat_err=0, sel_err=0, accept mask=0, all per-digit counts=0,
//   last codes=4'hF, FSM=COLLECT. Reset asserted mid-frame discards all partial digits.
//  Glyph table (g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F -- identical to the bcd encoder.
//   Any other pattern -> code 4'hF (invalid).
//  Sample with digit_sel not one-hot (zero or >1 bit): ignored entirely; sel_err <= 1.
//  Legal sample for digit d, code c:
//   - c invalid: pat_err pulses next cycle; cnt[d]<=0; last[d]<=F; digit d not accepted.
//   - c==last[d]: cnt[d] <= min(cnt[d]+1, STABLE_CNT). c!=last[d]: last[d]<=c, cnt[d]<=1.
//   - When updated cnt[d]==STABLE_CNT: shadow[d]<=c, accept[d]<=1 (re-acceptance overwrites shadow).
//  FSM: COLLECT -> EMIT on the edge where accept mask becomes all-ones;
//   EMIT (1 cycle): frame_vld=1, bcd_out=shadow, accept mask cleared; -> COLLECT.
//  Latency: frame_vld and new bcd_out registered 1 cycle after the completing sample.
//  Simultaneous: a sample arriving in the EMIT cycle is processed into the NEW frame (mask clear
//   happens first, then the new accept bit is set). cnt/last are NOT cleared at frame end, so a steady
//   display yields one frame per full scan once warmed up.
//  Digits may arrive in any order; repeats of an accepted digit before frame completion just refresh it.
// CONFIGURATION
//  ALT_GLYPH_EN defined: additionally accept alternate glyphs 6=7C, 7=27, 9=67 (decode to 6/7/9).
//  Undefined: those patterns are invalid (code F, pat_err).
// STRUCTURE
//  Package seg7_pkg: glyph constants SEG_0..SEG_9 (+ alternates), CODE_INV=4'hF, FSM state encoding.
//  Sub-module seg7_to_bcd: combinational 7-bit -> {valid,4-bit} lookup, instantiated once on seg;
//   shares the ALT_GLYPH_EN switch. Top holds per-digit cnt/last/shadow arrays, mask and FSM.
// TESTING
//  1 Reset: hold reset 3 cycles -> all outputs 0, sel_err 0; no frame_vld without samples.
//  2 Stable frame: DIGITS=4,STABLE_CNT=2, scan d0..d3 = 4,3,2,1 twice -> one frame_vld, bcd_out=16'h1234,
//    1 cycle after the 8th sample; a third scan -> second frame_vld, same value.
//  3 Glitch: d2 sees 5B,7F,5B,5B -> d2 accepted only after last two; frame holds 2 in nibble 2.
//  4 Invalid: seg=7'h49 on d1 -> pat_err pulse next cycle, no frame until d1 re-stabilises.
//  5 Bad select: digit_sel=4'b0110 with sample -> sel_err=1 sticky, cnt/mask unchanged.
//  6 Mid-frame reset after 3 digits accepted -> mask cleared; full 2x scan needed for next frame.
//  7 Config: seg=7'h7C on all digits -> frame 16'h6666 with ALT_GLYPH_EN; pat_err per sample without.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan decoder: glyph patterns (g..a), the
// invalid code, the stability counter width and the frame FSM encoding.
package seg7_pkg;

  localparam int         CNT_W    = 4;
  localparam logic [3:0] CODE_INV = 4'hF;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  // Alternate glyphs some drivers use (6 without tail, 7 with a hook, 9 without tail).
  localparam logic [6:0] SEG_6_ALT = 7'h7C;
  localparam logic [6:0] SEG_7_ALT = 7'h27;
  localparam logic [6:0] SEG_9_ALT = 7'h67;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_EMIT    = 1'b1
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } glyph_t;

  function automatic glyph_t mk_glyph(input logic [3:0] code);
    return '{valid: 1'b1, code: code};
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment pattern -> {valid, BCD} lookup.
// Define ALT_GLYPH_EN to also accept the alternate 6/7/9 glyphs.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output glyph_t     o_glyph
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    o_glyph = '{valid: 1'b0, code: CODE_INV};
    case (i_seg)
      SEG_0: o_glyph = mk_glyph(4'd0);
      SEG_1: o_glyph = mk_glyph(4'd1);
      SEG_2: o_glyph = mk_glyph(4'd2);
      SEG_3: o_glyph = mk_glyph(4'd3);
      SEG_4: o_glyph = mk_glyph(4'd4);
      SEG_5: o_glyph = mk_glyph(4'd5);
      SEG_6: o_glyph = mk_glyph(4'd6);
      SEG_7: o_glyph = mk_glyph(4'd7);
      SEG_8: o_glyph = mk_glyph(4'd8);
      SEG_9: o_glyph = mk_glyph(4'd9);
`ifdef ALT_GLYPH_EN
      SEG_6_ALT: o_glyph = mk_glyph(4'd6);
      SEG_7_ALT: o_glyph = mk_glyph(4'd7);
      SEG_9_ALT: o_glyph = mk_glyph(4'd9);
`else
      SEG_6_ALT, SEG_7_ALT, SEG_9_ALT: o_glyph = '{valid: 1'b0, code: CODE_INV};
`endif
      default: o_glyph = '{valid: 1'b0, code: CODE_INV};
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed 7-segment bus, debounces each digit and emits one BCD word per full frame.
// Optional ALT_GLYPH_EN (passed through to seg7_to_bcd) widens the accepted glyph set.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample,
  input  logic [DIGITS-1:0]     digit_sel,
  input  logic [6:0]            seg,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  frame_vld,
  output logic                  pat_err,
  output logic                  sel_err
);

  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CNT);

  glyph_t              w_glyph;
  logic                w_onehot;
  logic                w_legal;

  logic [CNT_W-1:0]    r_cnt        [DIGITS];
  logic [CNT_W-1:0]    w_cnt_nxt    [DIGITS];
  logic [3:0]          r_last       [DIGITS];
  logic [3:0]          w_last_nxt   [DIGITS];
  logic [3:0]          r_shadow     [DIGITS];
  logic [3:0]          w_shadow_nxt [DIGITS];

  logic [DIGITS-1:0]   r_mask;
  logic [DIGITS-1:0]   w_acc_set;
  logic [DIGITS-1:0]   w_mask_nxt;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_emit_go;

  logic [4*DIGITS-1:0] r_bcd;
  logic                r_pat_err;
  logic                r_sel_err;

  seg7_to_bcd u_dec (
    .i_seg   (seg),
    .o_glyph (w_glyph)
  );

  assign w_onehot = $onehot(digit_sel);
  assign w_legal  = sample & w_onehot;

  // Only the selected digit moves; the others hold their counters and codes.
  always_comb begin
    for (int d = 0; d < DIGITS; d++) begin
      w_cnt_nxt[d]    = r_cnt[d];
      w_last_nxt[d]   = r_last[d];
      w_shadow_nxt[d] = r_shadow[d];
      w_acc_set[d]    = 1'b0;
      if (w_legal && digit_sel[d]) begin
        if (!w_glyph.valid) begin
          w_cnt_nxt[d]  = '0;
          w_last_nxt[d] = CODE_INV;
        end else if (w_glyph.code == r_last[d]) begin
          w_cnt_nxt[d] = (r_cnt[d] >= STABLE) ? STABLE : r_cnt[d] + 1'b1;
        end else begin
          w_last_nxt[d] = w_glyph.code;
          w_cnt_nxt[d]  = CNT_W'(1);
        end
        if (w_glyph.valid && (w_cnt_nxt[d] == STABLE)) begin
          w_acc_set[d]    = 1'b1;
          w_shadow_nxt[d] = w_glyph.code;
        end
      end
    end
  end

  // The EMIT cycle clears the mask first, so a sample landing there starts the new frame.
  assign w_mask_nxt = ((r_state == ST_EMIT) ? '0 : r_mask) | w_acc_set;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_COLLECT: if (&w_mask_nxt) w_state_nxt = ST_EMIT;
      ST_EMIT:    w_state_nxt = ST_COLLECT;
      default:    w_state_nxt = ST_COLLECT;
    endcase
  end

  assign w_emit_go = (r_state == ST_COLLECT) && (w_state_nxt == ST_EMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      r_state   <= ST_COLLECT;
      r_mask    <= '0;
      r_bcd     <= '0;
      r_pat_err <= 1'b0;
      r_sel_err <= 1'b0;
      for (int d = 0; d < DIGITS; d++) begin
        r_cnt[d]  <= '0;
        r_last[d] <= CODE_INV;
      end
    end else begin
      r_state   <= w_state_nxt;
      r_mask    <= w_mask_nxt;
      r_pat_err <= w_legal & ~w_glyph.valid;
      r_sel_err <= r_sel_err | (sample & ~w_onehot);
      for (int d = 0; d < DIGITS; d++) begin
        r_cnt[d]  <= w_cnt_nxt[d];
        r_last[d] <= w_last_nxt[d];
      end
      if (w_emit_go) begin
        for (int d = 0; d < DIGITS; d++) r_bcd[4*d +: 4] <= w_shadow_nxt[d];
      end
    end
  end

  // NOTE: shadow is deliberately not reset: a digit's shadow is only read after its accept bit
  // was set in the current frame, and the mask itself is reset.
  always_ff @(posedge clk) begin
    for (int d = 0; d < DIGITS; d++) r_shadow[d] <= w_shadow_nxt[d];
  end

  assign bcd_out   = r_bcd;
  assign frame_vld = (r_state == ST_EMIT);
  assign pat_err   = r_pat_err;
  assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed scenarios plus randomized scans,
// checked against a sliding-window reference model of the display semantics.
module tb_seg7_scan_decoder;

  localparam int DIGITS     = 4;
  localparam int STABLE_CNT = 2;
  localparam int BW         = 4 * DIGITS;

  localparam logic [6:0] GLYPH [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic              clk = 1'b0;
  logic              reset;
  logic              sample;
  logic [DIGITS-1:0] digit_sel;
  logic [6:0]        seg;
  logic [BW-1:0]     bcd_out;
  logic              frame_vld;
  logic              pat_err;
  logic              sel_err;

  int checks = 0;
  int errors = 0;
  int obs_frames = 0;
  int obs_pat = 0;

  // Reference model: last STABLE_CNT codes per digit, accepted set of the current frame.
  logic [3:0]    m_hist [DIGITS][STABLE_CNT];
  logic          m_acc  [DIGITS];
  logic [3:0]    m_val  [DIGITS];
  logic          m_fv, m_pe, m_se;
  logic [BW-1:0] m_bcd;

  seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CNT(STABLE_CNT)) dut (
    .clk       (clk),
    .reset     (reset),
    .sample    (sample),
    .digit_sel (digit_sel),
    .seg       (seg),
    .bcd_out   (bcd_out),
    .frame_vld (frame_vld),
    .pat_err   (pat_err),
    .sel_err   (sel_err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_decode(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (GLYPH[i] == s) return 4'(i);
`ifdef ALT_GLYPH_EN
    if (s == 7'h7C) return 4'd6;
    if (s == 7'h27) return 4'd7;
    if (s == 7'h67) return 4'd9;
`endif
    return 4'hF;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < DIGITS; d++) begin
      for (int k = 0; k < STABLE_CNT; k++) m_hist[d][k] = 4'hF;
      m_acc[d] = 1'b0;
      m_val[d] = 4'h0;
    end
    m_fv = 1'b0; m_pe = 1'b0; m_se = 1'b0; m_bcd = '0;
  endtask

  task automatic model_update(input logic s, input logic [DIGITS-1:0] sel, input logic [6:0] sg);
    int d;
    logic [3:0] c;
    bit stable;
    bit full;
    m_fv = 1'b0;
    m_pe = 1'b0;
    if (!s) return;
    if ($countones(sel) != 1) begin
      m_se = 1'b1;
      return;
    end
    d = 0;
    for (int k = 0; k < DIGITS; k++) if (sel[k]) d = k;
    c = ref_decode(sg);
    m_pe = (c == 4'hF);
    for (int k = STABLE_CNT - 1; k > 0; k--) m_hist[d][k] = m_hist[d][k-1];
    m_hist[d][0] = c;
    stable = (c != 4'hF);
    for (int k = 0; k < STABLE_CNT; k++) if (m_hist[d][k] != c) stable = 1'b0;
    if (stable) begin
      m_acc[d] = 1'b1;
      m_val[d] = c;
    end
    full = 1'b1;
    for (int k = 0; k < DIGITS; k++) if (!m_acc[k]) full = 1'b0;
    if (full) begin
      m_fv = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
        m_bcd[4*k +: 4] = m_val[k];
        m_acc[k] = 1'b0;
      end
    end
  endtask

  // Drive one cycle of bus input, advance the model on the edge, land on the next negedge.
  task automatic step(input logic s, input logic [DIGITS-1:0] sel, input logic [6:0] sg);
    sample = s; digit_sel = sel; seg = sg;
    @(posedge clk);
    model_update(s, sel, sg);
    @(negedge clk);
    if (frame_vld === 1'b1) obs_frames++;
    if (pat_err === 1'b1) obs_pat++;
  endtask

  task automatic apply_reset();
    sample = 1'b0; digit_sel = '0; seg = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [DIGITS-1:0] sel_of(input int d);
    logic [DIGITS-1:0] v;
    v = '0;
    v[d] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    apply_reset();
    checks++;
    if (bcd_out !== '0 || frame_vld !== 1'b0 || pat_err !== 1'b0 || sel_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: bcd=%h fv=%b pe=%b se=%b, expected all zero",
               bcd_out, frame_vld, pat_err, sel_err);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, '0);
      checks++;
      if (frame_vld !== 1'b0 || sel_err !== 1'b0 || bcd_out !== '0) begin
        errors++;
        $display("FAIL reset_idle%0d: fv=%b se=%b bcd=%h, expected 0 0 0", i, frame_vld, sel_err, bcd_out);
      end
    end
  endtask

  task automatic test_stable_frame();
    int f0;
    apply_reset();
    f0 = obs_frames;
    for (int p = 0; p < 3; p++) begin
      for (int d = 0; d < DIGITS; d++) begin
        step(1'b1, sel_of(d), GLYPH[DIGITS - d]);
        checks++;
        if (frame_vld !== m_fv || bcd_out !== m_bcd || pat_err !== m_pe || sel_err !== m_se) begin
          errors++;
          $display("FAIL stable p%0d d%0d: fv=%b bcd=%h pe=%b se=%b expected fv=%b bcd=%h pe=%b se=%b",
                   p, d, frame_vld, bcd_out, pat_err, sel_err, m_fv, m_bcd, m_pe, m_se);
        end
      end
      if (p > 0) begin
        checks++;
        if (frame_vld !== 1'b1 || bcd_out !== 16'h1234 || (obs_frames - f0) != p) begin
          errors++;
          $display("FAIL stable_frame scan%0d: fv=%b bcd=%h frames=%0d, expected 1 1234 %0d",
                   p, frame_vld, bcd_out, obs_frames - f0, p);
        end
      end
    end
  endtask

  task automatic test_glitch();
    logic [6:0] d2_seq [4];
    int order [3];
    d2_seq = '{7'h5B, 7'h7F, 7'h5B, 7'h5B};
    order  = '{0, 1, 3};
    apply_reset();
    for (int p = 0; p < 2; p++) begin
      for (int j = 0; j < 3; j++) begin
        step(1'b1, sel_of(order[j]), GLYPH[DIGITS - order[j]]);
        checks++;
        if (frame_vld !== m_fv || bcd_out !== m_bcd || pat_err !== m_pe || sel_err !== m_se) begin
          errors++;
          $display("FAIL glitch warm d%0d: fv=%b bcd=%h pe=%b expected fv=%b bcd=%h pe=%b",
                   order[j], frame_vld, bcd_out, pat_err, m_fv, m_bcd, m_pe);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, sel_of(2), d2_seq[i]);
      checks++;
      if (frame_vld !== m_fv || bcd_out !== m_bcd || pat_err !== m_pe || sel_err !== m_se) begin
        errors++;
        $display("FAIL glitch d2 s%0d: fv=%b bcd=%h pe=%b expected fv=%b bcd=%h pe=%b",
                 i, frame_vld, bcd_out, pat_err, m_fv, m_bcd, m_pe);
      end
      checks++;
      if (frame_vld !== (i == 3) || (i == 3 && bcd_out[11:8] !== 4'd2)) begin
        errors++;
        $display("FAIL glitch accept s%0d: fv=%b nibble2=%h, expected fv=%b nibble2=2",
                 i, frame_vld, bcd_out[11:8], (i == 3));
      end
    end
  endtask

  task automatic test_invalid();
    int f0;
    apply_reset();
    for (int p = 0; p < 2; p++)
      for (int d = 0; d < DIGITS; d++) step(1'b1, sel_of(d), GLYPH[DIGITS - d]);
    f0 = obs_frames;
    step(1'b1, sel_of(0), GLYPH[4]);
    step(1'b1, sel_of(1), 7'h49);
    checks++;
    if (pat_err !== 1'b1 || pat_err !== m_pe) begin
      errors++;
      $display("FAIL invalid pat_err: got %b expected 1", pat_err);
    end
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: step(1'b1, sel_of(2), GLYPH[2]);
        1: step(1'b1, sel_of(3), GLYPH[1]);
        default: step(1'b1, sel_of(1), GLYPH[3]);
      endcase
      checks++;
      if (frame_vld !== m_fv || bcd_out !== m_bcd || pat_err !== m_pe || sel_err !== m_se) begin
        errors++;
        $display("FAIL invalid s%0d: fv=%b bcd=%h pe=%b expected fv=%b bcd=%h pe=%b",
                 i, frame_vld, bcd_out, pat_err, m_fv, m_bcd, m_pe);
      end
    end
    checks++;
    if (frame_vld !== 1'b1 || (obs_frames - f0) != 1 || bcd_out !== 16'h1234) begin
      errors++;
      $display("FAIL invalid restabilise: fv=%b frames=%0d bcd=%h, expected 1 1 1234",
               frame_vld, obs_frames - f0, bcd_out);
    end
  endtask

  task automatic test_bad_select();
    int f0;
    step(1'b1, 4'b0110, GLYPH[5]);
    checks++;
    if (sel_err !== 1'b1 || pat_err !== 1'b0) begin
      errors++;
      $display("FAIL bad_select: se=%b pe=%b, expected 1 0", sel_err, pat_err);
    end
    step(1'b1, 4'b0000, GLYPH[5]);
    f0 = obs_frames;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) step(1'b1, sel_of(i), GLYPH[DIGITS - i]);
      else step(1'b0, '0, '0);
      checks++;
      if (frame_vld !== m_fv || bcd_out !== m_bcd || pat_err !== m_pe || sel_err !== 1'b1) begin
        errors++;
        $display("FAIL bad_select after s%0d: fv=%b bcd=%h se=%b expected fv=%b bcd=%h se=1",
                 i, frame_vld, bcd_out, sel_err, m_fv, m_bcd);
      end
    end
    checks++;
    if ((obs_frames - f0) != 1) begin
      errors++;
      $display("FAIL bad_select frames: got %0d expected 1", obs_frames - f0);
    end
  endtask

  task automatic test_random();
    int tgt [DIGITS];
    int r, d;
    logic [DIGITS-1:0] sel;
    for (int i = 0; i < 400; i++) begin
      if (i % 48 == 0) for (int k = 0; k < DIGITS; k++) tgt[k] = $urandom_range(0, 9);
      r = $urandom_range(0, 99);
      d = (r < 70) ? (i % DIGITS) : $urandom_range(0, DIGITS - 1);
      if (r < 8) begin
        step(1'b0, DIGITS'($urandom), 7'($urandom));
      end else if (r < 11) begin
        sel = DIGITS'($urandom);
        if ($countones(sel) == 1) sel = '0;
        step(1'b1, sel, GLYPH[tgt[d]]);
      end else if (r < 16) begin
        step(1'b1, sel_of(d), 7'($urandom));
      end else begin
        step(1'b1, sel_of(d), GLYPH[tgt[d]]);
      end
      checks++;
      if (frame_vld !== m_fv || bcd_out !== m_bcd || pat_err !== m_pe || sel_err !== m_se) begin
        errors++;
        $display("FAIL random c%0d: fv=%b bcd=%h pe=%b se=%b expected fv=%b bcd=%h pe=%b se=%b",
                 i, frame_vld, bcd_out, pat_err, sel_err, m_fv, m_bcd, m_pe, m_se);
      end
    end
  endtask

  task automatic test_mid_reset();
    int f0;
    apply_reset();
    for (int p = 0; p < 2; p++)
      for (int dd = 0; dd < 3; dd++) step(1'b1, sel_of(dd), GLYPH[7 - dd]);
    apply_reset();
    f0 = obs_frames;
    for (int p = 0; p < 2; p++) begin
      for (int dd = 0; dd < DIGITS; dd++) begin
        step(1'b1, sel_of(dd), GLYPH[7 - dd]);
        checks++;
        if (frame_vld !== m_fv || bcd_out !== m_bcd || sel_err !== m_se) begin
          errors++;
          $display("FAIL mid_reset p%0d d%0d: fv=%b bcd=%h se=%b expected fv=%b bcd=%h se=%b",
                   p, dd, frame_vld, bcd_out, sel_err, m_fv, m_bcd, m_se);
        end
      end
      checks++;
      if ((obs_frames - f0) != p) begin
        errors++;
        $display("FAIL mid_reset frames after scan%0d: got %0d expected %0d", p, obs_frames - f0, p);
      end
    end
  endtask

  task automatic test_alt_glyph();
    int f0, p0;
    apply_reset();
    f0 = obs_frames;
    p0 = obs_pat;
    for (int p = 0; p < 2; p++) begin
      for (int dd = 0; dd < DIGITS; dd++) begin
        step(1'b1, sel_of(dd), 7'h7C);
        checks++;
        if (frame_vld !== m_fv || bcd_out !== m_bcd || pat_err !== m_pe) begin
          errors++;
          $display("FAIL alt p%0d d%0d: fv=%b bcd=%h pe=%b expected fv=%b bcd=%h pe=%b",
                   p, dd, frame_vld, bcd_out, pat_err, m_fv, m_bcd, m_pe);
        end
      end
    end
    checks++;
`ifdef ALT_GLYPH_EN
    if ((obs_frames - f0) != 1 || bcd_out !== 16'h6666 || (obs_pat - p0) != 0) begin
      errors++;
      $display("FAIL alt_enabled: frames=%0d bcd=%h pat=%0d, expected 1 6666 0",
               obs_frames - f0, bcd_out, obs_pat - p0);
    end
`else
    if ((obs_frames - f0) != 0 || (obs_pat - p0) != 2 * DIGITS) begin
      errors++;
      $display("FAIL alt_disabled: frames=%0d pat=%0d, expected 0 %0d",
               obs_frames - f0, obs_pat - p0, 2 * DIGITS);
    end
`endif
  endtask

  initial begin
    reset = 1'b1; sample = 1'b0; digit_sel = '0; seg = '0;
    model_reset();
    test_reset();
    test_stable_frame();
    test_glitch();
    test_invalid();
    test_bad_select();
    test_random();
    test_mid_reset();
    test_alt_glyph();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
